// File: rtl/pipeline_ctrl_gen.sv
// Pipeline hazard controller: fixed-priority arbitration of hazard sources,
// per-stage stall/flush generation, one-shot flush episodes, a sequenced
// trap FSM and saturating stall/flush performance counters.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | no trap in progress; a trap pulse may be pending
//   TRAP_FLUSH | trap flush cycle; entered combinationally from IDLE, never registered
//   TRAP_WAIT  | front end held until the PC is redirected to the trap vector
module pipeline_ctrl_gen #(
    parameter int                       STAGES      = 6,
    parameter int                       NREQ        = 4,
    parameter logic [NREQ*STAGES-1:0]   STALL_MASKS = 24'b011111_000010_000111_000011,
    parameter logic [NREQ*STAGES-1:0]   FLUSH_MASKS = 24'b100000_001110_001000_000000,
    parameter logic [NREQ-1:0]          ONESHOT     = 4'b0100,
    parameter logic [NREQ-1:0]          HOLD_MASK   = 4'b1000,
    parameter logic [STAGES-1:0]        TRAP_STALL  = 6'b000001,
    parameter logic [STAGES-1:0]        TRAP_FLUSH  = 6'b011110,
    parameter int                       CNT_W       = 32,
    localparam int                      IW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic              trap_req_i,
    input  logic              trap_redirect_i,
    input  logic              clr_cnt_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              win_valid_o,
    output logic [IW-1:0]     win_idx_o,
    output logic              trap_busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {IDLE, TRAP_FLUSH_S, TRAP_WAIT} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   ep_q, ep_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic [STAGES-1:0] stall_c, flush_c;
    logic              use_src, trap_go, hold_any, req_any, busy_c;
    int                src, hold_idx, top_idx;

    // State register: FSM, trap pending flag and one-shot episode flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ep_q    <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ep_q    <= ep_d;
            pend_q  <= pend_d;
        end
    end

    // Arbitration, output selection and next-state logic.
    always_comb begin
        hold_any = 1'b0;
        hold_idx = 0;
        req_any  = 1'b0;
        top_idx  = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_i[i] && HOLD_MASK[i]) begin
                hold_any = 1'b1;
                hold_idx = i;
            end
            if (req_i[i]) begin
                req_any = 1'b1;
                top_idx = i;
            end
        end

        // The flush cycle is the IDLE cycle in which entry is allowed, so a
        // trap pulse with no memory-side hold acts in the same cycle.
        trap_go = (state_q == IDLE) && (pend_q || trap_req_i) && !hold_any;
        busy_c  = trap_go || (state_q != IDLE);

        stall_c = '0;
        flush_c = '0;
        use_src = 1'b0;
        src     = 0;
        if (hold_any) begin
            use_src = 1'b1;
            src     = hold_idx;
        end else if (trap_go) begin
            stall_c = TRAP_STALL;
            flush_c = TRAP_FLUSH;
        end else if (state_q == TRAP_WAIT) begin
            stall_c = TRAP_STALL;
        end else if (req_any) begin
            use_src = 1'b1;
            src     = top_idx;
        end
        if (use_src) begin
            stall_c = STALL_MASKS[src*STAGES +: STAGES];
            if (!(ONESHOT[src] && ep_q[src]))
                flush_c = FLUSH_MASKS[src*STAGES +: STAGES];
        end

        // Episode flag survives while a higher source wins; drops with the request.
        ep_d = ep_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!req_i[i])
                ep_d[i] = 1'b0;
            else if (use_src && (src == i) && ONESHOT[i])
                ep_d[i] = 1'b1;
        end

        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (trap_go) begin
                    state_d = TRAP_WAIT;
                    pend_d  = 1'b0;
                    ep_d    = '0;
                end else if (trap_req_i) begin
                    pend_d  = 1'b1;
                end
            end
            TRAP_WAIT: begin
                if (trap_redirect_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces a full flush with no stall on the pipeline registers.
    assign stall_o     = rst_n ? stall_c : '0;
    assign flush_o     = rst_n ? flush_c : '1;
    assign win_valid_o = rst_n && use_src;
    assign win_idx_o   = (rst_n && use_src) ? IW'(src) : '0;
    assign trap_busy_o = rst_n && busy_c;

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o[0] && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((flush_o != '0) && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_gen.sv
// Self-checking bench for pipeline_ctrl_gen (default parameters plus a
// 4-bit counter instance for saturation).
module tb_pipeline_ctrl_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       trap = 1'b0, redir = 1'b0, clr = 1'b0;
    logic [5:0] stall, flush;
    logic       wv, busy;
    logic [1:0] wi;
    logic [31:0] scnt, fcnt;

    logic [3:0] req_s = '0;
    logic       clr_s = 1'b0;
    logic [5:0] stall_s, flush_s;
    logic       wv_s, busy_s;
    logic [1:0] wi_s;
    logic [3:0] scnt_s, fcnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_gen u_dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .trap_req_i(trap),
        .trap_redirect_i(redir), .clr_cnt_i(clr),
        .stall_o(stall), .flush_o(flush), .win_valid_o(wv), .win_idx_o(wi),
        .trap_busy_o(busy), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    pipeline_ctrl_gen #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .req_i(req_s), .trap_req_i(1'b0),
        .trap_redirect_i(1'b0), .clr_cnt_i(clr_s),
        .stall_o(stall_s), .flush_o(flush_s), .win_valid_o(wv_s), .win_idx_o(wi_s),
        .trap_busy_o(busy_s), .stall_cnt_o(scnt_s), .flush_cnt_o(fcnt_s)
    );

    // Source behaviour written out as a table, source index = row.
    logic [5:0] SM [4] = '{6'b000011, 6'b000111, 6'b000010, 6'b011111};
    logic [5:0] FM [4] = '{6'b000000, 6'b001000, 6'b001110, 6'b100000};
    bit         OS [4] = '{0, 0, 1, 0};
    bit         HM [4] = '{0, 0, 0, 1};

    // Reference model state.
    bit     m_waiting;   // trap flushed, waiting for redirect
    bit     m_pend;
    bit     m_ep [4];
    longint m_sc, m_fc;

    // Expected outputs for the current cycle (filled by model_eval).
    logic [5:0] e_stall, e_flush;
    bit         e_wv, e_busy, e_enter;
    int         e_drv;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_waiting = 0; m_pend = 0; m_sc = 0; m_fc = 0;
        for (int i = 0; i < 4; i++) m_ep[i] = 0;
    endtask

    task automatic model_eval(input logic [3:0] r, input logic t);
        int hold_src, top_src;
        hold_src = -1; top_src = -1;
        for (int i = 3; i >= 0; i--) begin
            if (r[i] && HM[i] && hold_src < 0) hold_src = i;
            if (r[i] && top_src < 0) top_src = i;
        end
        e_enter = !m_waiting && (m_pend || t) && (hold_src < 0);
        e_drv   = -1;
        e_stall = '0; e_flush = '0;
        if (hold_src >= 0)     e_drv = hold_src;
        else if (e_enter)      begin e_stall = 6'b000001; e_flush = 6'b011110; end
        else if (m_waiting)    e_stall = 6'b000001;
        else                   e_drv = top_src;
        if (e_drv >= 0) begin
            e_stall = SM[e_drv];
            e_flush = (OS[e_drv] && m_ep[e_drv]) ? 6'b0 : FM[e_drv];
        end
        e_wv   = (e_drv >= 0);
        e_busy = e_enter || m_waiting;
    endtask

    task automatic model_update(input logic [3:0] r, input logic t, input logic rd, input logic c);
        longint maxv = 64'hFFFF_FFFF;
        bit was_waiting = m_waiting;
        if (c) begin m_sc = 0; m_fc = 0; end
        else begin
            if (e_stall[0] && m_sc < maxv) m_sc++;
            if (e_flush != 0 && m_fc < maxv) m_fc++;
        end
        for (int i = 0; i < 4; i++)
            if (!r[i]) m_ep[i] = 0;
            else if (e_drv == i && OS[i]) m_ep[i] = 1;
        if (e_enter) begin
            m_waiting = 1; m_pend = 0;
            for (int i = 0; i < 4; i++) m_ep[i] = 0;
        end else if (!was_waiting && t) m_pend = 1;
        if (was_waiting && rd) m_waiting = 0;
    endtask

    // Drive at the negedge, check combinational outputs 2 ns later.
    task automatic drive_and_check(input logic [3:0] r, input logic t, input logic rd, input logic c);
        req = r; trap = t; redir = rd; clr = c;
        #2;
        model_eval(r, t);
        check("stall", stall, e_stall);
        check("flush", flush, e_flush);
        check("win_valid", wv, e_wv);
        check("win_idx", wi, e_wv ? e_drv : 0);
        check("trap_busy", busy, e_busy);
        check("stall_cnt", scnt, m_sc);
        check("flush_cnt", fcnt, m_fc);
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update(req, trap, redir, clr);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] r;
        logic       t, rd;
        logic [5:0] s, f;
        logic       v;
        logic [1:0] w;
        logic       b;
    } vec_t;

    vec_t vecs [$];

    initial begin
        // ---- reset state ----
        model_reset();
        #3;
        check("rst_stall", stall, 0);
        check("rst_flush", flush, 6'b111111);
        check("rst_win_valid", wv, 0);
        check("rst_win_idx", wi, 0);
        check("rst_busy", busy, 0);
        check("rst_stall_cnt", scnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---- table-driven sequence ----
        //               req      trap rd  stall      flush      v  w  busy
        vecs.push_back('{4'b0100, 0, 0, 6'b000010, 6'b001110, 1, 2, 0});
        vecs.push_back('{4'b0100, 0, 0, 6'b000010, 6'b000000, 1, 2, 0});
        vecs.push_back('{4'b0100, 0, 0, 6'b000010, 6'b000000, 1, 2, 0});
        vecs.push_back('{4'b0000, 0, 0, 6'b000000, 6'b000000, 0, 0, 0});
        vecs.push_back('{4'b0100, 0, 0, 6'b000010, 6'b001110, 1, 2, 0});
        vecs.push_back('{4'b0110, 0, 0, 6'b000010, 6'b000000, 1, 2, 0});
        vecs.push_back('{4'b1110, 0, 0, 6'b011111, 6'b100000, 1, 3, 0});
        vecs.push_back('{4'b0000, 0, 0, 6'b000000, 6'b000000, 0, 0, 0});
        vecs.push_back('{4'b1000, 1, 0, 6'b011111, 6'b100000, 1, 3, 0});
        vecs.push_back('{4'b1000, 0, 0, 6'b011111, 6'b100000, 1, 3, 0});
        vecs.push_back('{4'b1000, 0, 0, 6'b011111, 6'b100000, 1, 3, 0});
        vecs.push_back('{4'b1000, 0, 0, 6'b011111, 6'b100000, 1, 3, 0});
        vecs.push_back('{4'b0000, 0, 0, 6'b000001, 6'b011110, 0, 0, 1});
        vecs.push_back('{4'b0000, 0, 0, 6'b000001, 6'b000000, 0, 0, 1});
        vecs.push_back('{4'b0100, 0, 0, 6'b000001, 6'b000000, 0, 0, 1});
        vecs.push_back('{4'b0000, 0, 1, 6'b000001, 6'b000000, 0, 0, 1});
        vecs.push_back('{4'b0000, 0, 0, 6'b000000, 6'b000000, 0, 0, 0});
        vecs.push_back('{4'b0000, 1, 0, 6'b000001, 6'b011110, 0, 0, 1});
        vecs.push_back('{4'b0000, 1, 0, 6'b000001, 6'b000000, 0, 0, 1});
        vecs.push_back('{4'b0000, 0, 1, 6'b000001, 6'b000000, 0, 0, 1});
        vecs.push_back('{4'b0000, 0, 1, 6'b000000, 6'b000000, 0, 0, 0});
        vecs.push_back('{4'b0001, 0, 0, 6'b000011, 6'b000000, 1, 0, 0});
        vecs.push_back('{4'b1010, 0, 0, 6'b011111, 6'b100000, 1, 3, 0});
        vecs.push_back('{4'b0010, 0, 0, 6'b000111, 6'b001000, 1, 1, 0});
        foreach (vecs[k]) begin
            drive_and_check(vecs[k].r, vecs[k].t, vecs[k].rd, 1'b0);
            check($sformatf("vec%0d_stall", k), stall, vecs[k].s);
            check($sformatf("vec%0d_flush", k), flush, vecs[k].f);
            check($sformatf("vec%0d_win_valid", k), wv, vecs[k].v);
            check($sformatf("vec%0d_win_idx", k), wi, vecs[k].w);
            check($sformatf("vec%0d_busy", k), busy, vecs[k].b);
            finish_cycle();
        end

        // ---- reset asserted during TRAP_WAIT ----
        drive_and_check(4'b0000, 1'b1, 1'b0, 1'b0);
        finish_cycle();
        drive_and_check(4'b0000, 1'b0, 1'b0, 1'b0);
        check("wait_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_flush", flush, 6'b111111);
        check("midrst_busy", busy, 0);
        check("midrst_win_valid", wv, 0);
        check("midrst_stall_cnt", scnt, 0);
        check("midrst_flush_cnt", fcnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_and_check(4'b0000, 1'b0, 1'b0, 1'b0);
        check("postrst_stall", stall, 0);
        check("postrst_flush", flush, 0);
        finish_cycle();

        // ---- counter value and clear ----
        drive_and_check(4'b0000, 1'b0, 1'b0, 1'b1);
        finish_cycle();
        repeat (10) begin
            drive_and_check(4'b0001, 1'b0, 1'b0, 1'b0);
            finish_cycle();
        end
        drive_and_check(4'b0001, 1'b0, 1'b0, 1'b1);
        check("cnt_before_clr", scnt, 10);
        finish_cycle();
        drive_and_check(4'b0000, 1'b0, 1'b0, 1'b0);
        check("cnt_after_clr", scnt, 0);
        finish_cycle();

        // ---- saturation on the 4-bit counter instance ----
        clr_s = 1'b1;
        drive_and_check(4'b0000, 1'b0, 1'b0, 1'b0);
        finish_cycle();
        clr_s = 1'b0; req_s = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            drive_and_check(4'b0000, 1'b0, 1'b0, 1'b0);
            check($sformatf("sat_cnt%0d", k), scnt_s, (k < 15) ? k : 15);
            finish_cycle();
        end
        drive_and_check(4'b0000, 1'b0, 1'b0, 1'b0);
        check("sat_final", scnt_s, 15);
        finish_cycle();
        req_s = 4'b0000;

        // ---- randomized traffic against the model ----
        begin
            logic [3:0] r = '0;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
                drive_and_check(r, $urandom_range(0, 15) == 0,
                                $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
                finish_cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
